// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory access per start, lane alignment and load extension.
// Optional ack-wait timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] data_m,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        en_fetch,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] data_m_q, data_m_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        req_legal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rd_shift;
  logic [31:0] load_val;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    req_legal = 1'b0;
    req_be    = 4'b0000;
    req_wdata = wdata;
    case (funct3)
      3'b000: begin req_legal = 1'b1;                     req_be = 4'b0001 << addr[1:0]; req_wdata = {4{wdata[7:0]}};  end
      3'b001: begin req_legal = ~addr[0];                 req_be = 4'b0011 << addr[1:0]; req_wdata = {2{wdata[15:0]}}; end
      3'b010: begin req_legal = (addr[1:0] == 2'b00);     req_be = 4'b1111;                                            end
      3'b100: begin req_legal = ~is_store;                req_be = 4'b0001 << addr[1:0];                               end
      3'b101: begin req_legal = ~is_store & ~addr[0];     req_be = 4'b0011 << addr[1:0];                               end
      default: req_legal = 1'b0;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend by access width.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {24'h000000, rd_shift[7:0]};
      3'b101:  load_val = {16'h0000, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    data_m_d    = data_m_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (start) begin
          f3_d  = funct3;
          off_d = addr[1:0];
          if (req_legal) begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_be_d    = req_be;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = is_store ? req_wdata : 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (mem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (!mem_we_q) data_m_d = load_val;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
`endif
        if (state_d == DONE) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b0000;
          mem_addr_d  = 32'h0;
          mem_wdata_d = 32'h0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      data_m_q    <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      data_m_q    <= data_m_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign en_fetch  = ~busy;
  assign done      = (state_q == DONE);
  assign err       = done & err_q;
  assign data_m    = data_m_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, illegal requests, reset abort, timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data_m;
  logic        busy;
  logic        done;
  logic        err;
  logic        en_fetch;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .data_m(data_m), .busy(busy), .done(done),
    .err(err), .en_fetch(en_fetch), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; issues a legal request, acks after 3 cycles of mem_req.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_dm, input string nm);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    check({nm, " mem_req"}, {31'b0, mem_req}, 32'd1);
    check({nm, " mem_we"}, {31'b0, mem_we}, {31'b0, st});
    check({nm, " mem_be"}, {28'b0, mem_be}, {28'b0, exp_be});
    check({nm, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
    if (st) check({nm, " mem_wdata"}, mem_wdata, exp_wdata);
    check({nm, " en_fetch"}, {31'b0, en_fetch}, 32'd0);
    // A start while busy must be dropped.
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h400; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    check({nm, " busy ignore addr"}, mem_addr, {a[31:2], 2'b00});
    check({nm, " busy ignore be"}, {28'b0, mem_be}, {28'b0, exp_be});
    @(negedge clk);
    check({nm, " no early done"}, {31'b0, done}, 32'd0);
    mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check({nm, " done"}, {31'b0, done}, 32'd1);
    check({nm, " err"}, {31'b0, err}, 32'd0);
    check({nm, " mem_req drop"}, {31'b0, mem_req}, 32'd0);
    check({nm, " data_m"}, data_m, exp_dm);
    @(negedge clk);
    check({nm, " done low"}, {31'b0, done}, 32'd0);
    check({nm, " idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic err_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_dm, input string nm);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    check({nm, " no mem_req"}, {31'b0, mem_req}, 32'd0);
    check({nm, " done"}, {31'b0, done}, 32'd1);
    check({nm, " err"}, {31'b0, err}, 32'd1);
    check({nm, " data_m kept"}, data_m, exp_dm);
    @(negedge clk);
    check({nm, " done low"}, {31'b0, done}, 32'd0);
    check({nm, " err low"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    #1;
    check("rst data_m", data_m, 32'h0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst en_fetch", {31'b0, en_fetch}, 32'd1);
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst mem_be", {28'b0, mem_be}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // Stray ack in IDLE: nothing must happen.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle ack done", {31'b0, done}, 32'd0);
    check("idle ack busy", {31'b0, busy}, 32'd0);

    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF, "LW");
    run_req(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80, "LB");
    run_req(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 4'b1000, 32'h0, 32'h0000_0080, "LBU");
    run_req(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 4'b1100, 32'h0, 32'hFFFF_80FF, "LH");
    run_req(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 4'b1100, 32'h0, 32'h0000_80FF, "LHU");
    run_req(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h1111_1111, 4'b1100, 32'hABCD_ABCD, 32'h0000_80FF, "SH");
    run_req(1'b1, 3'b000, 32'h201, 32'h1234_ABCD, 32'h2222_2222, 4'b0010, 32'hCDCD_CDCD, 32'h0000_80FF, "SB");
    run_req(1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'h3333_3333, 4'b1111, 32'hCAFE_F00D, 32'h0000_80FF, "SW");

    err_req(1'b0, 3'b010, 32'h101, 32'h0000_80FF, "LW misaligned");
    err_req(1'b0, 3'b011, 32'h100, 32'h0000_80FF, "f3 011");
    err_req(1'b0, 3'b101, 32'h103, 32'h0000_80FF, "LHU misaligned");
    err_req(1'b1, 3'b100, 32'h100, 32'h0000_80FF, "SBU illegal");

    // Reset in the middle of an access, then a late ack.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    start = 1'b0;
    check("abort mem_req before", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort mem_req", {31'b0, mem_req}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort en_fetch", {31'b0, en_fetch}, 32'd1);
    check("abort data_m", data_m, 32'h0);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late ack done", {31'b0, done}, 32'd0);
    check("late ack busy", {31'b0, busy}, 32'd0);
    check("late ack data_m", data_m, 32'h0);

    // Never acked access.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      check($sformatf("timeout wait %0d", i), {30'b0, busy, done}, 32'd2);
    end
    @(negedge clk);
    check("timeout done", {31'b0, done}, 32'd1);
    check("timeout err", {31'b0, err}, 32'd1);
    check("timeout mem_req", {31'b0, mem_req}, 32'd0);
    check("timeout data_m", data_m, 32'h0);
`else
    repeat (20) @(negedge clk);
    check("no timeout busy", {31'b0, busy}, 32'd1);
    check("no timeout mem_req", {31'b0, mem_req}, 32'd1);
    check("no timeout done", {31'b0, done}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late ack done", {31'b0, done}, 32'd1);
    check("late ack data_m", data_m, 32'h0BAD_F00D);
`endif
    @(negedge clk);
    check("final idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, ack-wait limit in cycles; used only when LSU_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request strobe from control, sampled only in IDLE.
REQ-005 Port: is_store  input  1  1 = store, 0 = load; sampled with start.
REQ-006 Port: funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU); sampled with start.
REQ-007 Port: addr  input  32  byte address (ALU result); sampled with start.
REQ-008 Port: wdata  input  32  store data (register read port 2); sampled with start.
REQ-009 Port: data_m  output  32  load result toward write-back mux.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: err  output  1  valid with done: misaligned, illegal funct3, or timeout.
REQ-013 Port: en_fetch  output  1  equals ~busy; stalls PC/fetch during access.
REQ-014 Port: mem_req  output  1  memory request, registered.
REQ-015 Port: mem_we  output  1  write enable, registered.
REQ-016 Port: mem_be  output  4  byte enables, registered.
REQ-017 Port: mem_addr  output  32  word address, {addr[31:2],2'b00}, registered.
REQ-018 Port: mem_wdata  output  32  lane-aligned store data, registered.
REQ-019 Port: mem_rdata  input  32  read data, valid in the mem_ack cycle.
REQ-020 Port: mem_ack  input  1  completion from memory; ignored unless mem_req=1.

Function
REQ-021 FSM states: IDLE, ACCESS, DONE; IDLE+start -> ACCESS (legal) or DONE with err=1 (illegal); ACCESS+mem_ack -> DONE; DONE -> IDLE unconditionally.
REQ-022 Legality: funct3 011/110/111 illegal (stores: only 000/001/010 legal); H/HU with addr[0]=1 or W with addr[1:0]!=0 misaligned; illegal or misaligned requests issue no memory access.
REQ-023 Latency: mem_req high from cycle after start until and including ack cycle; done high the cycle after ack; minimum start-to-done = 2 cycles.
REQ-024 mem_req, mem_we, mem_be, mem_addr, mem_wdata stay constant throughout ACCESS.
REQ-025 mem_be: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111; loads drive the same mask with mem_we=0.
REQ-026 mem_wdata: B replicates wdata[7:0] to all lanes; H replicates wdata[15:0] to both halves; W passes wdata.
REQ-027 Load extract: lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unmodified; captured into data_m on the ack cycle.
REQ-028 data_m holds its value until the next successful load; stores and errored requests leave data_m unchanged.
REQ-029 start while busy is ignored, not queued; mem_ack outside ACCESS is ignored.
REQ-030 done and err are both 0 outside DONE.

Reset
REQ-031 On rst low, immediately (asynchronously): state=IDLE, data_m=0, done=0, err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; busy=0, en_fetch=1.
REQ-032 Reset during ACCESS abandons the access; a late mem_ack after reset release is ignored.

Configuration
REQ-033 Macro LSU_TIMEOUT_EN defined: an 8+-bit counter clears on ACCESS entry and increments each ACCESS cycle; if it reaches TIMEOUT_CYCLES without mem_ack, FSM -> DONE with err=1, mem_req drops, data_m unchanged.
REQ-034 LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for mem_ack.

Verification
REQ-035 LW addr=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after mem_req -> mem_be=1111, mem_we=0, done 1 cycle after ack, data_m=0xDEADBEEF, err=0.
REQ-036 LB addr=0x103, mem_rdata=0x80FF_0000 -> mem_be=1000, data_m=0xFFFFFF80; LBU same -> data_m=0x00000080.
REQ-037 SH addr=0x202, wdata=0x1234ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; data_m unchanged.
REQ-038 LW addr=0x101 -> no mem_req, done+err next cycle; funct3=011 -> same response.
REQ-039 rst low while in ACCESS, then mem_ack after release -> mem_req=0 at once, busy=0, en_fetch=1, no done pulse.
REQ-040 With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, never ack -> done+err after 8 ACCESS cycles; without macro -> busy stays 1.
